// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    // imem_req stays high with imem_addr stable until imem_ack; a beat completes
    // on any cycle where imem_req && imem_ack, and imem_rdata is valid only then.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads every cycle unless stalled; flush inserts a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pcplus4_i,
    input  logic        valid_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d   = NOP_INSTR;
            pc_d      = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (!stall) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pcplus4_d = pcplus4_i;
            valid_d   = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, variable-latency memory handshake,
// stall skid buffer and branch redirect while a request is outstanding.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                PCSrcE,
    input  logic [31:0]         PCTargetE,
    input  logic                StallD,
    input  logic                FlushD,
    output logic [31:0]         InstrD,
    output logic [31:0]         PCD,
    output logic [31:0]         PCPlus4D,
    output logic                ValidD,
    output logic                FetchBusy,
    output fetch_state_t        dbg_state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  skid_q, skid_d;
    logic [31:0]  pend_q, pend_d;

    logic [31:0]  pcf_plus4;
    logic [31:0]  target;
    logic [31:0]  id_instr, id_pc, id_pcplus4;
    logic         id_valid;

    assign pcf_plus4 = pcf_q + 32'd4;
    assign target    = align_word(PCTargetE);

    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        skid_d     = skid_q;
        pend_d     = pend_q;
        id_instr   = NOP_INSTR;
        id_pc      = '0;
        id_pcplus4 = '0;
        id_valid   = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    if (PCSrcE) begin
                        pcf_d = target;
                    end else if (StallD) begin
                        skid_d  = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        id_instr   = imem.imem_rdata;
                        id_pc      = pcf_q;
                        id_pcplus4 = pcf_plus4;
                        id_valid   = 1'b1;
                        pcf_d      = pcf_plus4;
                    end
                end else if (PCSrcE) begin
                    pend_d  = target;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                // The outstanding word belongs to the squashed path; newest redirect wins.
                if (PCSrcE) pend_d = target;
                if (imem.imem_ack) begin
                    pcf_d   = PCSrcE ? target : pend_q;
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = target;
                    state_d = ST_FETCH;
                end else if (!StallD) begin
                    id_instr   = skid_q;
                    id_pc      = pcf_q;
                    id_pcplus4 = pcf_plus4;
                    id_valid   = 1'b1;
                    pcf_d      = pcf_plus4;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pcf_q   <= RESET_PC;
            skid_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            skid_q  <= skid_d;
            pend_q  <= pend_d;
        end
    end

    // Request never depends on ack, so memory may answer combinationally.
    assign imem.imem_req  = !rst && (state_q != ST_HOLD);
    assign imem.imem_addr = {pcf_q[31:2], 2'b00};
    assign FetchBusy      = !rst && ((state_q == ST_DROP) ||
                                     (state_q == ST_FETCH && !imem.imem_ack));
    assign dbg_state      = state_q;

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .stall     (StallD),
        .flush     (FlushD),
        .instr_i   (id_instr),
        .pc_i      (id_pc),
        .pcplus4_i (id_pcplus4),
        .valid_i   (id_valid),
        .instr_o   (InstrD),
        .pc_o      (PCD),
        .pcplus4_o (PCPlus4D),
        .valid_o   (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle model comparison plus literal checkpoints.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        stall;
    logic        flush;
    logic [31:0] instr_d, pc_d, pcp4_d;
    logic        valid_d, busy;
    fetch_state_t dbg_state;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem_bus),
        .PCSrcE    (pcsrc),
        .PCTargetE (tgt),
        .StallD    (stall),
        .FlushD    (flush),
        .InstrD    (instr_d),
        .PCD       (pc_d),
        .PCPlus4D  (pcp4_d),
        .ValidD    (valid_d),
        .FetchBusy (busy),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    always_comb imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ack, input logic ps, input logic [31:0] t,
                        input logic st, input logic fl);
        imem_bus.imem_ack = ack;
        pcsrc = ps;
        tgt   = t;
        stall = st;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: where the PC is, whether a word sits parked waiting for
    // decode, and whether a redirect is waiting for a stale reply to drain.
    logic [31:0] m_pc, m_skid, m_tgt;
    bit          m_parked, m_draining;
    logic [31:0] m_instr, m_pcd, m_pcp4;
    bit          m_valid;
    logic [31:0] n_instr, n_pcd, n_pcp4, al;
    bit          n_valid;

    always @(posedge clk) begin
        al = {tgt[31:2], 2'b00};
        if (rst) begin
            m_pc = 32'h0; m_skid = '0; m_tgt = '0;
            m_parked = 0; m_draining = 0;
            m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 0;
        end else begin
            n_instr = NOP; n_pcd = '0; n_pcp4 = '0; n_valid = 0;
            if (m_parked) begin
                if (pcsrc) begin
                    m_pc = al; m_parked = 0;
                end else if (!stall) begin
                    n_instr = m_skid; n_pcd = m_pc; n_pcp4 = m_pc + 32'd4; n_valid = 1;
                    m_pc = m_pc + 32'd4; m_parked = 0;
                end
            end else if (m_draining) begin
                if (pcsrc) m_tgt = al;
                if (imem_bus.imem_ack) begin
                    m_pc = m_tgt; m_draining = 0;
                end
            end else if (imem_bus.imem_ack) begin
                if (pcsrc) m_pc = al;
                else if (stall) begin
                    m_skid = mem_word(m_pc); m_parked = 1;
                end else begin
                    n_instr = mem_word(m_pc); n_pcd = m_pc; n_pcp4 = m_pc + 32'd4; n_valid = 1;
                    m_pc = m_pc + 32'd4;
                end
            end else if (pcsrc) begin
                m_tgt = al; m_draining = 1;
            end
            if (flush) begin
                m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 0;
            end else if (!stall) begin
                m_instr = n_instr; m_pcd = n_pcd; m_pcp4 = n_pcp4; m_valid = n_valid;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_instr", instr_d, m_instr);
            chk("cyc_pcd", pc_d, m_pcd);
            chk("cyc_pcp4", pcp4_d, m_pcp4);
            chk("cyc_valid", {31'b0, valid_d}, {31'b0, m_valid});
            chk("cyc_req", {31'b0, imem_bus.imem_req}, {31'b0, !rst && !m_parked});
            chk("cyc_addr", imem_bus.imem_addr, m_pc);
            chk("cyc_busy", {31'b0, busy},
                {31'b0, !rst && !m_parked && (m_draining || !imem_bus.imem_ack)});
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pcsrc = 0; tgt = '0; stall = 0; flush = 0;
        imem_bus.imem_ack = 0;
        do_reset();
        chk_on = 1'b1;
        chk("rst_valid", {31'b0, valid_d}, 32'd0);
        chk("rst_pcd", pc_d, 32'h0);
        chk("rst_instr", instr_d, NOP);

        // zero-wait streaming
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            chk("stream_pcd", pc_d, 32'(i * 4));
            chk("stream_pcp4", pcp4_d, 32'(i * 4 + 4));
            chk("stream_valid", {31'b0, valid_d}, 32'd1);
        end

        // three wait states on address 0x8
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("wait_addr", imem_bus.imem_addr, 32'h8);
            chk("wait_busy", {31'b0, busy}, 32'd1);
            chk("wait_valid", {31'b0, valid_d}, 32'd0);
        end
        step(1, 0, 0, 0, 0);
        chk("wait_instr", instr_d, 32'hC0D6_0008);
        chk("wait_pcd", pc_d, 32'h8);

        // stall as 0xDEADBEEF returns from 0x10
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("hold_state", 32'(dbg_state), 32'(ST_HOLD));
        chk("hold_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("hold_pcd", pc_d, 32'hC);
        step(0, 0, 0, 1, 0);
        chk("hold2_pcd", pc_d, 32'hC);
        step(0, 0, 0, 0, 0);
        chk("rel_instr", instr_d, 32'hDEAD_BEEF);
        chk("rel_pcd", pc_d, 32'h10);
        chk("rel_addr", imem_bus.imem_addr, 32'h14);

        // redirect during an unacked fetch of 0x20
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h103, 0, 0);
        chk("drop_state", 32'(dbg_state), 32'(ST_DROP));
        chk("drop_addr", imem_bus.imem_addr, 32'h20);
        step(0, 0, 0, 0, 0);
        chk("drop_addr2", imem_bus.imem_addr, 32'h20);
        step(1, 0, 0, 0, 0);
        chk("drop_valid", {31'b0, valid_d}, 32'd0);
        chk("redir_addr", imem_bus.imem_addr, 32'h100);
        step(1, 0, 0, 0, 0);
        chk("redir_pcd", pc_d, 32'h100);

        // second redirect while draining overrides the first
        step(0, 1, 32'h200, 0, 0);
        step(0, 1, 32'h306, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("latest_addr", imem_bus.imem_addr, 32'h304);

        // PC wrap and flush overriding stall
        step(1, 1, 32'hFFFF_FFFF, 0, 0);
        chk("wrap_addr0", imem_bus.imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pcp4_d, 32'h0);
        chk("wrap_addr", imem_bus.imem_addr, 32'h0);
        step(1, 0, 0, 1, 1);
        chk("flush_valid", {31'b0, valid_d}, 32'd0);
        chk("flush_instr", instr_d, NOP);
        chk("flush_pcd", pc_d, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("flush_rel_instr", instr_d, 32'hC0DE_0000);
        chk("flush_rel_valid", {31'b0, valid_d}, 32'd1);

        // reset pulsed in HOLD with an ack present
        step(1, 0, 0, 1, 0);
        chk("prerst_state", 32'(dbg_state), 32'(ST_HOLD));
        rst = 1'b1;
        step(1, 0, 0, 0, 0);
        chk("rst2_valid", {31'b0, valid_d}, 32'd0);
        chk("rst2_pcd", pc_d, 32'h0);
        chk("rst2_pcp4", pcp4_d, 32'h0);
        chk("rst2_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("rst2_busy", {31'b0, busy}, 32'd0);
        chk("rst2_state", 32'(dbg_state), 32'(ST_FETCH));
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("post_rst_addr", imem_bus.imem_addr, 32'h0);

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
        step(1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
